// File: rtl/hx8352_fill_sequencer_if.sv
// Command/data bus between the fill sequencer (master) and hx8352_controller (slave).
interface hx8352_fill_sequencer_if;
   logic [15:0] cmd_out;
   logic        cmd_step;
   logic [15:0] data_out;
   logic        data_step;
   logic        busy;
   logic        init_done;

   modport master (output cmd_out, cmd_step, data_out, data_step, input busy, init_done);
   modport slave  (input cmd_out, cmd_step, data_out, data_step, output busy, init_done);
endinterface

// File: rtl/hx8352_fill_sequencer.sv
// Fills a rectangular LCD window with one RGB565 colour through hx8352_controller.
// Optional HX8352_FILL_ROWINC_EN: pixel word becomes colour + (y - y0) for a stripe gradient.
module hx8352_fill_sequencer #(
   parameter int H_RES = 240,
   parameter int V_RES = 400,
   parameter int GUARD = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           abort,
   input  logic [8:0]                     x0,
   input  logic [8:0]                     x1,
   input  logic [8:0]                     y0,
   input  logic [8:0]                     y1,
   input  logic [15:0]                    colour,
   output logic                           active,
   output logic                           done,
   output logic [1:0]                     status,
   hx8352_fill_sequencer_if.master        bus
);
   localparam int         GW    = (GUARD < 2) ? 1 : $clog2(GUARD + 1);
   localparam logic [9:0] H_LIM = 10'(H_RES);
   localparam logic [9:0] V_LIM = 10'(V_RES);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ARM, S_REG, S_RAMW, S_PIX, S_DONE} state_t;
   state_t state, state_nx;

   logic [8:0]    x0_q, x1_q, y0_q, y1_q, col, row, fld;
   logic [15:0]   colour_q, cmd_hold, data_hold, reg_word, pix_word;
   logic [3:0]    reg_idx;
   logic [16:0]   pix_cnt, n_pix;
   logic [GW-1:0] guard;
   logic          abort_req, abort_now, step_free, step_ok, win_bad;
   logic          set_bad, set_abort;

   assign win_bad   = (x0_q > x1_q) || (y0_q > y1_q) ||
                      ({1'b0, x1_q} >= H_LIM) || ({1'b0, y1_q} >= V_LIM);
   assign abort_now = abort | abort_req;
   // busy is only trusted once the post-strobe guard window has elapsed
   assign step_free = (guard == '0) && !bus.busy;
   assign step_ok   = step_free && bus.init_done && !abort_now;

   always_comb begin
      case (reg_idx[3:2])
         2'd0:    fld = x0_q;
         2'd1:    fld = x1_q;
         2'd2:    fld = y0_q;
         default: fld = y1_q;
      endcase
      reg_word = reg_idx[1] ? {8'h00, fld[7:0]} : {15'h0000, fld[8]};
   end

`ifdef HX8352_FILL_ROWINC_EN
   assign pix_word = colour_q + {7'h00, row - y0_q};
`else
   assign pix_word = colour_q;
`endif

   always_comb begin
      state_nx      = state;
      bus.cmd_step  = 1'b0;
      bus.data_step = 1'b0;
      bus.cmd_out   = cmd_hold;
      bus.data_out  = data_hold;
      set_bad       = 1'b0;
      set_abort     = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_CHECK;
         S_CHECK: begin
            state_nx = win_bad ? S_DONE : S_ARM;
            set_bad  = win_bad;
         end
         S_ARM: begin
            if (abort_now) begin
               state_nx  = S_DONE;
               set_abort = 1'b1;
            end else if (step_free && bus.init_done) begin
               state_nx = S_REG;
            end
         end
         S_REG, S_RAMW, S_PIX: begin
            if (step_free && abort_now) begin
               state_nx  = S_DONE;
               set_abort = 1'b1;
            end else if (step_ok) begin
               if (state == S_REG) begin
                  // even index: register select, odd index: its data word
                  if (!reg_idx[0]) begin
                     bus.cmd_step = 1'b1;
                     bus.cmd_out  = 16'h0002 + {13'h0000, reg_idx[3:1]};
                  end else begin
                     bus.data_step = 1'b1;
                     bus.data_out  = reg_word;
                  end
                  if (reg_idx == 4'hF) state_nx = S_RAMW;
               end else if (state == S_RAMW) begin
                  bus.cmd_step = 1'b1;
                  bus.cmd_out  = 16'h0022;
                  state_nx     = S_PIX;
               end else begin
                  bus.data_step = 1'b1;
                  bus.data_out  = pix_word;
                  if (pix_cnt == n_pix - 17'd1) state_nx = S_DONE;
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign active = (state != S_IDLE) && (state != S_DONE);
   assign done   = (state == S_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         x0_q      <= '0;
         x1_q      <= '0;
         y0_q      <= '0;
         y1_q      <= '0;
         colour_q  <= '0;
         cmd_hold  <= '0;
         data_hold <= '0;
         reg_idx   <= '0;
         pix_cnt   <= '0;
         n_pix     <= '0;
         col       <= '0;
         row       <= '0;
         guard     <= '0;
         abort_req <= 1'b0;
         status    <= 2'b00;
      end else begin
         state     <= state_nx;
         cmd_hold  <= bus.cmd_out;
         data_hold <= bus.data_out;
         if (bus.cmd_step || bus.data_step) guard <= GW'(GUARD);
         else if (guard != '0)              guard <= guard - 1'b1;
         if (state == S_IDLE && start) begin
            x0_q      <= x0;
            x1_q      <= x1;
            y0_q      <= y0;
            y1_q      <= y1;
            colour_q  <= colour;
            status    <= 2'b00;
            abort_req <= 1'b0;
            reg_idx   <= '0;
         end
         if (state == S_CHECK)
            n_pix <= 17'(x1_q - x0_q + 9'd1) * 17'(y1_q - y0_q + 9'd1);
         if (set_bad)   status <= 2'b01;
         if (set_abort) status <= 2'b10;
         if (abort && (state inside {S_ARM, S_REG, S_RAMW, S_PIX})) abort_req <= 1'b1;
         if (state == S_REG && step_ok) reg_idx <= reg_idx + 4'd1;
         if (state == S_RAMW && step_ok) begin
            pix_cnt <= '0;
            col     <= x0_q;
            row     <= y0_q;
         end
         if (state == S_PIX && step_ok) begin
            pix_cnt <= pix_cnt + 17'd1;
            if (col == x1_q) begin
               col <= x0_q;
               row <= row + 9'd1;
            end else begin
               col <= col + 9'd1;
            end
         end
      end
   end
endmodule

// File: doc/hx8352_fill_sequencer.md
Name: hx8352_fill_sequencer

Overview:
- Sequences the hx8352_controller to fill a rectangular window of the LCD with one RGB565 colour.
- Waits for controller init, programs the column/row window registers, issues memory-write (0x22), then streams one data word per pixel.
- Sits between system-level pattern logic and hx8352_controller's cmd_in/cmd_step/data_in/data_step/busy interface.
- Replaces the free-running pixel drive currently fed straight into data_in.

Parameters:
- H_RES, 240, panel width in pixels; legal x is 0..H_RES-1.
- V_RES, 400, panel height in pixels; legal y is 0..V_RES-1.
- GUARD, 2, cycles after any step pulse during which busy is ignored (covers controller busy-assert latency); minimum 1.

Ports:
- clk  in  1  system clock (clk_50M domain)
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  level; stop after the write in flight
- x0, x1  in  9 each  column start/end, inclusive
- y0, y1  in  9 each  row start/end, inclusive
- colour  in  16  RGB565 fill value, latched at start
- init_done  in  1  from controller
- busy  in  1  from controller
- cmd_out  out  16  register index to controller cmd_in
- cmd_step  out  1  one-cycle command-write strobe
- data_out  out  16  word to controller data_in
- data_step  out  1  one-cycle data-write strobe
- active  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- status  out  2  00 ok, 01 bad window, 10 aborted; held until next accepted start

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, counters 0.
- IDLE: on start=1, latch x0/x1/y0/y1/colour; set active next cycle; go CHECK. A start outside IDLE is ignored.
- CHECK (1 cycle): the window is bad if x0>x1, y0>y1, x1>=H_RES or y1>=V_RES.
  - Bad: go DONE with status=01; no step is ever issued.
  - Good: go ARM.
- ARM: wait for init_done=1 and busy=0, then go REG.
- REG: 8 register writes, each a cmd step followed by a data step:
  - 0x02 <- x0[8], 0x03 <- x0[7:0]
  - 0x04 <- x1[8], 0x05 <- x1[7:0]
  - 0x06 <- y0[8], 0x07 <- y0[7:0]
  - 0x08 <- y1[8], 0x09 <- y1[7:0]
  - Data words are zero-extended to 16 bits.
- RAMW: one cmd step with 0x0022.
- PIX: N = (x1-x0+1)*(y1-y0+1) data steps, all carrying the latched colour. The pixel counter is 17 bits (max 96000). Column and row counters wrap column x1 -> x0 with row+1.
- Step rule, applied to every step:
  - The strobe is high exactly 1 cycle, with cmd_out/data_out valid in that same cycle.
  - After the strobe, ignore busy for GUARD cycles, then wait for busy=0 before the next strobe.
  - cmd_step and data_step are never high together.
  - Minimum step spacing is GUARD+1 cycles.
- cmd_out/data_out hold their last value between strobes.
- abort=1 in ARM/REG/RAMW/PIX: finish the in-flight step (including its guard and busy wait), issue no further steps, go DONE with status=10. An abort during CHECK is ignored.
- DONE (1 cycle): done=1; active drops to 0 in the same cycle; return to IDLE.
- init_done falling mid-run: the sequencer pauses before the next strobe until init_done=1 again; no data is lost.
- Reset low mid-operation: immediate return to IDLE; any partial window on the panel is left as-is.
- 1x1 window: 17 steps total (16 REG + RAMW), then 1 pixel.

Optional Feature:
- Macro: HX8352_FILL_ROWINC_EN.
- Defined: the pixel word is colour + row_offset (mod 2^16), where row_offset = current y - y0. This produces a horizontal-stripe test gradient.
- Undefined: every pixel equals the latched colour, and the adder is not instantiated.

Test Plan:
- Window (0,0)-(1,1), colour 0xF800, busy model asserting 1 cycle after each strobe for 3 cycles -> 8 cmd/data pairs with values 02:00 03:00 04:00 05:01 06:00 07:00 08:00 09:01, then cmd 0x0022, then exactly 4 data_step of 0xF800; done pulses once; status=00.
- x0=10, x1=5 -> no strobes; done pulses 2 cycles after start; status=01. Repeat with y1=400 -> status=01.
- init_done held 0 for 100 cycles after start -> no strobes, active=1; first cmd_step occurs after init_done rises and busy is low.
- Full window (0,0)-(239,399) -> exactly 96000 data_step, counter does not wrap; last pixel followed by done.
- abort asserted during the 3rd pixel of a 4x4 fill -> 3 pixels written, then done with status=10; a new start is accepted the cycle after done.
- rst pulsed low during the REG phase -> all outputs 0 asynchronously; a fresh start reissues from register 0x02. With HX8352_FILL_ROWINC_EN defined, a 2x3 fill of 0x0001 yields data 1,1,2,2,3,3.
